triangle_pwm_deadtime: RTL and testbench

//  Downstream consumer of the triangle-wave counter. Compares the N-bit triangle

---
 rtl/triangle_pwm_deadtime.sv | 189 ++++++++++++++++++
 tb/tb_triangle_pwm_deadtime.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_pwm_deadtime.sv
// ============================================================================
// triangle_pwm_deadtime
// ----------------------------------------------------------------------------
// Center-aligned PWM with complementary, dead-time protected drives.
//
// The block consumes the count of an external triangle-wave counter and
// compares it against a double-buffered duty value. A new duty value is
// accepted on a valid/ready port into a single pending slot and is only
// promoted to the active compare value at the triangle valley. That way every
// carrier period is generated with a single, consistent duty value.
//
// The raw comparator result is registered and then fed to a small dead-time
// state machine. The machine makes sure the high-side and low-side drives are
// never on together. Between them there is always a both-off gap of
// deadtime+1 clock cycles.
//
// Parameters
//   N     width of the triangle count and of the duty value
//   DT_W  width of the dead-time setting
//
// Ports
//   clk         in   1     clock
//   rst         in   1     synchronous, active-high reset
//   ena         in   1     enable that also advances the triangle counter
//   tri_in      in   N     triangle count, 0..2^N-1..0
//   duty_in     in   N     requested duty compare value
//   duty_valid  in   1     duty_in is valid
//   duty_ready  out  1     pending duty slot is empty; transfer on valid&ready
//   deadtime    in   DT_W  dead-time setting, sampled when DEAD is entered
//   out_hi      out  1     high-side drive
//   out_lo      out  1     low-side drive
//   cycle_start out  1     one-cycle pulse: valley seen, active duty updated
// ============================================================================
module triangle_pwm_deadtime #(
   parameter int N    = 8,
   parameter int DT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic [N-1:0]    tri_in,
   input  logic [N-1:0]    duty_in,
   input  logic            duty_valid,
   output logic            duty_ready,
   input  logic [DT_W-1:0] deadtime,
   output logic            out_hi,
   output logic            out_lo,
   output logic            cycle_start
);

   // Drive states. DEAD is the only state in which both drives are off.
   // It is also the reset state, so no drive can be on while leaving reset.
   typedef enum logic [1:0] {
      DEAD  = 2'd0,
      ON_HI = 2'd1,
      ON_LO = 2'd2
   } pwm_state_t;

   // A valley only counts when the counter actually advances.
   // Holding at zero with ena low is not a new carrier period.
   logic            valley;
   logic            accept;

   logic [N-1:0]    duty_active;
   logic [N-1:0]    pend;
   logic            pend_full;

   logic            raw_q;

   pwm_state_t      state;
   pwm_state_t      state_nxt;
   logic [DT_W-1:0] dt_cnt;
   logic [DT_W-1:0] dt_cnt_nxt;
   logic            target;
   logic            target_nxt;

   assign valley     = ena & (tri_in == '0);
   assign duty_ready = ~pend_full & ~rst;
   assign accept     = duty_valid & duty_ready;

   // Pending duty slot.
   // A beat is only taken while the slot is empty. A beat can therefore
   // never arrive at the same edge as a valley that drains a full slot. When
   // a beat and a valley share an edge with the slot empty, the beat stays
   // pending and is applied at the following valley.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         pend_full <= 1'b0;
      end else if (accept) begin
         pend      <= duty_in;
         pend_full <= 1'b1;
      end else if (valley) begin
         pend_full <= 1'b0;
      end
   end

   // Active duty register and period-start pulse.
   // The active compare value only changes at a valley. A valley with an
   // empty slot still reports the start of a new period.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_active <= '0;
         cycle_start <= 1'b0;
      end else begin
         cycle_start <= valley;
         if (valley && pend_full) begin
            duty_active <= pend;
         end
      end
   end

   // Registered comparator.
   // This runs on every clock, independent of ena, so the PWM keeps
   // tracking tri_in even while the counter is held.
   // Duty 0 gives a constant low. Duty 2^N-1 is high everywhere except at
   // the top of the triangle.
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q <= 1'b0;
      end else begin
         raw_q <= (tri_in < duty_active);
      end
   end

   // Dead-time state register. Reset forces DEAD, so both drives turn off
   // at the very next edge, whatever they were doing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= DEAD;
         dt_cnt <= '0;
         target <= 1'b0;
      end else begin
         state  <= state_nxt;
         dt_cnt <= dt_cnt_nxt;
         target <= target_nxt;
      end
   end

   // Dead-time next-state logic.
   // Leaving an ON state always passes through DEAD and loads the gap
   // counter. Inside DEAD, target remembers which drive is wanted next. If
   // raw_q changes its mind before the gap has expired, the gap restarts
   // from the full setting. A short comparator blip therefore never turns
   // into a one-cycle pulse on either drive. The counter runs on clk, so the
   // gap length does not depend on ena.
   always_comb begin
      state_nxt  = state;
      dt_cnt_nxt = dt_cnt;
      target_nxt = target;
      case (state)
         ON_HI: begin
            if (!raw_q) begin
               state_nxt  = DEAD;
               target_nxt = 1'b0;
               dt_cnt_nxt = deadtime;
            end
         end
         ON_LO: begin
            if (raw_q) begin
               state_nxt  = DEAD;
               target_nxt = 1'b1;
               dt_cnt_nxt = deadtime;
            end
         end
         DEAD: begin
            if (raw_q != target) begin
               target_nxt = raw_q;
               dt_cnt_nxt = deadtime;
            end else if (dt_cnt == '0) begin
               state_nxt = target ? ON_HI : ON_LO;
            end else begin
               dt_cnt_nxt = dt_cnt - DT_W'(1);
            end
         end
         default: begin
            state_nxt  = DEAD;
            target_nxt = 1'b0;
            dt_cnt_nxt = '0;
         end
      endcase
   end

   // Drives are a pure decode of the registered state. Only one ON state
   // can be encoded at a time, so the two drives are mutually exclusive.
   assign out_hi = (state == ON_HI);
   assign out_lo = (state == ON_LO);

endmodule

// File: tb/tb_triangle_pwm_deadtime.sv
// ============================================================================
// tb_triangle_pwm_deadtime
// ----------------------------------------------------------------------------
// Randomized bench for triangle_pwm_deadtime. A triangle counter and a duty
// requester are modelled in the bench. Expected drive levels come from a
// run-length view of the comparator:
//   A drive is on once the comparator has held its level for deadtime+2
//   consecutive edges.
// Duty buffering is modelled as a one-entry pending slot that is emptied at
// valleys.
// ============================================================================
module tb_triangle_pwm_deadtime;

   localparam int N    = 8;
   localparam int DT_W = 6;
   localparam int TOP  = (1 << N) - 1;

   logic            clk;
   logic            rst;
   logic            ena;
   logic [N-1:0]    tri_in;
   logic [N-1:0]    duty_in;
   logic            duty_valid;
   logic            duty_ready;
   logic [DT_W-1:0] deadtime;
   logic            out_hi;
   logic            out_lo;
   logic            cycle_start;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_duty;
   int m_pend;
   bit m_pf;
   bit m_raw;
   bit m_cs;
   int run_val;
   int run_len;
   bit exp_hi;
   bit exp_lo;

   // Stimulus state
   int tri_val;
   bit tri_up;
   int offer_mode;
   int duty_q[$];

   triangle_pwm_deadtime #(.N(N), .DT_W(DT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .tri_in      (tri_in),
      .duty_in     (duty_in),
      .duty_valid  (duty_valid),
      .duty_ready  (duty_ready),
      .deadtime    (deadtime),
      .out_hi      (out_hi),
      .out_lo      (out_lo),
      .cycle_start (cycle_start)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle:
   //   1. Drive the inputs.
   //   2. Check duty_ready before the edge.
   //   3. Advance the model.
   //   4. Check the outputs 1 time unit after the edge.
   task automatic applyStimulus(input bit r, input bit e, input int t);
      bit acc;
      bit vly;
      bit r_seen;
      int d;
      acc = 1'b0;
      rst    = r;
      ena    = e;
      tri_in = N'(t);
      if (!duty_valid && duty_q.size() > 0) begin
         if ((offer_mode == 0 && $urandom_range(0, 3) == 0) ||
             (offer_mode == 1 && e && t == 0)) begin
            duty_valid = 1'b1;
            duty_in    = N'(duty_q.pop_front());
         end
      end
      #2;
      checkOutput("duty_ready", 32'(duty_ready), 32'(!m_pf && !r));
      d = int'(deadtime);
      if (r) begin
         m_duty  = 0;
         m_pend  = 0;
         m_pf    = 1'b0;
         m_raw   = 1'b0;
         m_cs    = 1'b0;
         run_val = 0;
         run_len = d + 1;
      end else begin
         acc    = duty_valid && !m_pf;
         vly    = e && (t == 0);
         r_seen = m_raw;
         m_raw  = (t < m_duty);
         if (vly && m_pf) m_duty = m_pend;
         if (acc) begin
            m_pend = int'(duty_in);
            m_pf   = 1'b1;
         end else if (vly) begin
            m_pf = 1'b0;
         end
         m_cs = vly;
         if (int'(r_seen) == run_val) begin
            if (run_len < 1000) run_len++;
         end else begin
            run_val = int'(r_seen);
            run_len = 1;
         end
      end
      exp_hi = !r && run_val == 1 && run_len >= d + 2;
      exp_lo = !r && run_val == 0 && run_len >= d + 2;
      @(posedge clk);
      #1;
      if (acc) duty_valid = 1'b0;
      checkOutput("out_hi", 32'(out_hi), 32'(exp_hi));
      checkOutput("out_lo", 32'(out_lo), 32'(exp_lo));
      checkOutput("cycle_start", 32'(cycle_start), 32'(m_cs));
      checkOutput("both_on", 32'(out_hi & out_lo), 0);
   endtask

   // One cycle of the modelled triangle counter. The count advances only
   // on edges where ena is high.
   task automatic triStep(input bit e);
      if (duty_q.size() == 0) duty_q.push_back($urandom_range(0, TOP));
      applyStimulus(1'b0, e, tri_val);
      if (e) begin
         if (tri_up) begin
            if (tri_val == TOP) begin tri_up = 1'b0; tri_val = TOP - 1; end
            else tri_val++;
         end else begin
            if (tri_val == 0) begin tri_up = 1'b1; tri_val = 1; end
            else tri_val--;
         end
      end
   endtask

   task automatic resetSteps(input int n);
      for (int i = 0; i < n; i++) begin
         tri_val = 0;
         tri_up  = 1'b1;
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 0);
      end
   endtask

   initial begin
      bit found;
      rst        = 1'b1;
      ena        = 1'b0;
      tri_in     = '0;
      duty_in    = '0;
      duty_valid = 1'b0;
      deadtime   = DT_W'(3);
      offer_mode = 0;
      tri_val    = 0;
      tri_up     = 1'b1;
      m_duty = 0; m_pend = 0; m_pf = 0; m_raw = 0; m_cs = 0;
      run_val = 0; run_len = 4;

      // Reset, then a directed duty sequence over several triangle periods
      duty_q = {64, 200, 30, 0, 255, 128};
      resetSteps(3);
      for (int i = 0; i < 3600; i++) triStep(1'b1);
      for (int i = 0; i < 1200; i++) triStep(1'($urandom_range(0, 9) != 0));

      // Offers timed to land exactly on a valley with the slot empty
      offer_mode = 1;
      for (int i = 0; i < 1100; i++) triStep(1'b1);
      offer_mode = 0;

      // Longer dead time, then comparator chatter with the counter held
      deadtime = DT_W'(7);
      resetSteps(2);
      duty_q.delete();
      duty_q.push_back(128);
      for (int i = 0; i < 600; i++) triStep(1'b1);
      for (int i = 0; i < 600; i++) begin
         tri_val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TOP)
                                               : 124 + $urandom_range(0, 8);
         applyStimulus(1'b0, 1'b0, tri_val);
      end
      tri_val = 0;
      tri_up  = 1'b1;

      // Reset while the high-side drive is on
      duty_q.delete();
      duty_q.push_back(100);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         triStep(1'b1);
         if (exp_hi) found = 1'b1;
      end
      checkOutput("wait_hi", 32'(found), 1);
      resetSteps(2);

      // Minimum and small random dead times
      deadtime = DT_W'(0);
      resetSteps(1);
      for (int i = 0; i < 1100; i++) triStep(1'($urandom_range(0, 7) != 0));
      deadtime = DT_W'($urandom_range(1, 10));
      resetSteps(2);
      for (int i = 0; i < 1100; i++) triStep(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
